// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state
// encodings, iteration count and the divide-by-zero quotient value.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_unit_if.sv
// CPU-side request/result bundle of the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int DATA_W = 32
);

  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic              mthi_i;
  logic              mtlo_i;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i, mthi_i, mtlo_i,
    input  busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i, mthi_i, mtlo_i,
    output busy_o, done_o, hi_o, lo_o
  );

endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iteration datapath: shift-add multiply or restoring divide on
// unsigned magnitudes, one step per cycle in a shared 64-bit accumulator.
module muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic                is_div,
  input  logic [DATA_W-1:0]   a_mag,
  input  logic [DATA_W-1:0]   b_mag,
  output logic [2*DATA_W-1:0] acc
);

  logic [DATA_W-1:0]   b_q;
  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] acc_next;
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;

  // Multiply adds into the upper half then shifts right; divide shifts the
  // remainder left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    diff = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, b_q};
    acc_next = acc_q;
    if (is_div) begin
      if (!diff[DATA_W]) begin
        acc_next = {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_next = {acc_q[2*DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      b_q   <= '0;
    end else if (load) begin
      acc_q <= {{DATA_W{1'b0}}, a_mag};
      b_q   <= b_mag;
    end else if (step) begin
      acc_q <= acc_next;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers: FSM, iteration
// counter, sign handling and MTHI/MTLO writes around the muldiv_iter datapath.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  state_t              state_q;
  logic [CNT_W-1:0]    count_q;
  op_t                 op_q;
  logic [DATA_W-1:0]   rs_q;
  logic                neg_rs_q;
  logic                neg_rt_q;
  logic                rt_zero_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  logic                signed_in;
  logic                neg_rs_in;
  logic                neg_rt_in;
  logic [DATA_W-1:0]   rs_mag;
  logic [DATA_W-1:0]   rt_mag;
  logic                accept;
  logic                mt_window;
  logic                is_div_q;
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   res_hi;
  logic [DATA_W-1:0]   res_lo;

  assign accept    = (state_q == ST_IDLE) && bus.start_i;
  assign mt_window = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU);

  // Operands enter the datapath as magnitudes; the signs are remembered
  // separately and reapplied in FIX.
  always_comb begin
    signed_in = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
    neg_rs_in = signed_in && bus.rs_data_i[DATA_W-1];
    neg_rt_in = signed_in && bus.rt_data_i[DATA_W-1];
    rs_mag    = neg_rs_in ? ('0 - bus.rs_data_i) : bus.rs_data_i;
    rt_mag    = neg_rt_in ? ('0 - bus.rt_data_i) : bus.rt_data_i;
  end

  muldiv_iter #(
    .DATA_W (DATA_W)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (accept),
    .step   (state_q == ST_CALC),
    .is_div (is_div_q),
    .a_mag  (rs_mag),
    .b_mag  (rt_mag),
    .acc    (acc)
  );

  // Quotient is negated on differing signs (truncation toward zero) and the
  // remainder follows the dividend; divide by zero overrides everything.
  always_comb begin
    res_hi = acc[2*DATA_W-1:DATA_W];
    res_lo = acc[DATA_W-1:0];
    case (op_q)
      OP_MULT: begin
        if (neg_rs_q ^ neg_rt_q) begin
          {res_hi, res_lo} = '0 - acc;
        end
      end
      OP_DIV: begin
        if (neg_rs_q ^ neg_rt_q) begin
          res_lo = '0 - acc[DATA_W-1:0];
        end
        if (neg_rs_q) begin
          res_hi = '0 - acc[2*DATA_W-1:DATA_W];
        end
      end
      default: begin
      end
    endcase
    if (is_div_q && rt_zero_q) begin
      res_hi = rs_q;
      res_lo = DATA_W'(DIV_ZERO_LO);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      op_q      <= OP_MULT;
      rs_q      <= '0;
      neg_rs_q  <= 1'b0;
      neg_rt_q  <= 1'b0;
      rt_zero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (mt_window && bus.mthi_i) begin
        hi_q <= bus.rs_data_i;
      end
      if (mt_window && bus.mtlo_i) begin
        lo_q <= bus.rs_data_i;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            op_q      <= op_t'(bus.op_i);
            rs_q      <= bus.rs_data_i;
            neg_rs_q  <= neg_rs_in;
            neg_rt_q  <= neg_rt_in;
            rt_zero_q <= (bus.rt_data_i == '0);
            count_q   <= CNT_W'(ITER - 1);
            state_q   <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (count_q == '0) begin
            state_q <= ST_FIX;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        ST_FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          state_q <= ST_DONE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign bus.done_o = (state_q == ST_DONE);
  assign bus.hi_o   = hi_q;
  assign bus.lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed results.
module tb_muldiv_unit;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  muldiv_unit_if #(.DATA_W(32)) bus();

  muldiv_unit #(
    .DATA_W (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Issues one operation and follows it to the done pulse; optionally writes
  // HI together with start, or disturbs the unit mid-CALC with start/MTLO.
  task automatic applyStimulus(input string tag, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input bit mtWith, input bit disturb,
                               input logic [31:0] holdLo,
                               input logic [31:0] expHi, input logic [31:0] expLo);
    int  busyCycles;
    int  doneAt;
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.rs_data_i = a;
    bus.rt_data_i = b;
    bus.mthi_i    = mtWith;
    @(negedge clk);
    bus.start_i   = 1'b0;
    bus.mthi_i    = 1'b0;
    bus.rs_data_i = $urandom;
    bus.rt_data_i = $urandom;
    if (mtWith) checkOutput({tag, "_mt_with_start"}, {32'h0, bus.hi_o}, {32'h0, a});
    busyCycles = 0;
    doneAt = -1;
    for (int i = 0; i < 60; i++) begin
      if (bus.busy_o) busyCycles++;
      if (bus.done_o) begin
        doneAt = i;
        break;
      end
      if (disturb && i == 5) begin
        bus.start_i   = 1'b1;
        bus.op_i      = 2'b11;
        bus.mtlo_i    = 1'b1;
        bus.rs_data_i = 32'hDEAD_BEEF;
        bus.rt_data_i = 32'h1;
      end
      if (disturb && i == 6) begin
        bus.start_i = 1'b0;
        bus.mtlo_i  = 1'b0;
      end
      if (disturb && i == 7) checkOutput({tag, "_lo_held"}, {32'h0, bus.lo_o}, {32'h0, holdLo});
      @(negedge clk);
    end
    checkOutput({tag, "_done_at"}, 64'(doneAt), 64'd33);
    checkOutput({tag, "_busy_cycles"}, 64'(busyCycles), 64'd33);
    checkOutput({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, {expHi, expLo});
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {63'h0, bus.done_o}, 64'h0);
  endtask

  initial begin
    bit sawDone;
    compared   = 0;
    mismatched = 0;
    reset         = 1'b1;
    bus.start_i   = 1'b0;
    bus.op_i      = 2'b00;
    bus.rs_data_i = '0;
    bus.rt_data_i = '0;
    bus.mthi_i    = 1'b0;
    bus.mtlo_i    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {63'h0, bus.busy_o}, 64'h0);
    checkOutput("rst_done", {63'h0, bus.done_o}, 64'h0);
    checkOutput("rst_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
    reset = 1'b0;

    applyStimulus("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0,
                  32'hFFFF_FFFE, 32'h0000_0001);
    applyStimulus("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, '0,
                  32'hFFFF_FFFF, 32'hFFFF_FFEB);
    applyStimulus("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0,
                  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus("divu_7_2", 2'b11, 32'd7, 32'd2, 1'b1, 1'b0, '0,
                  32'd1, 32'd3);
    applyStimulus("divu_zero", 2'b11, 32'h64, 32'h0, 1'b0, 1'b0, '0,
                  32'h64, 32'hFFFF_FFFF);
    applyStimulus("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0,
                  32'h0, 32'h8000_0000);
    applyStimulus("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'h0, 1'b0, 1'b0, '0,
                  32'hFFFF_FF00, 32'hFFFF_FFFF);

    // MTHI / MTLO in IDLE
    @(negedge clk);
    bus.mthi_i    = 1'b1;
    bus.rs_data_i = 32'h1234;
    @(negedge clk);
    bus.mthi_i    = 1'b0;
    checkOutput("mthi_idle", {32'h0, bus.hi_o}, 64'h1234);
    bus.mtlo_i    = 1'b1;
    bus.rs_data_i = 32'h55;
    @(negedge clk);
    bus.mtlo_i    = 1'b0;
    checkOutput("mtlo_idle", {bus.hi_o, bus.lo_o}, {32'h1234, 32'h55});

    applyStimulus("multu_disturb", 2'b01, 32'd5, 32'd6, 1'b0, 1'b1, 32'h55,
                  32'h0, 32'd30);

    // Reset in the 10th CALC cycle
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = 2'b00;
    bus.rs_data_i = 32'd1000;
    bus.rt_data_i = 32'd1000;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid_rst_busy", {63'h0, bus.busy_o}, 64'h0);
    checkOutput("mid_rst_hilo", {bus.hi_o, bus.lo_o}, 64'h0);
    sawDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done_o || bus.busy_o) sawDone = 1'b1;
      @(negedge clk);
    end
    checkOutput("mid_rst_no_result", {63'h0, sawDone}, 64'h0);

    applyStimulus("multu_2_3", 2'b01, 32'd2, 32'd3, 1'b0, 1'b0, '0,
                  32'h0, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
